// File: rtl/bcd_counter_pkg.sv
// Shared definitions for the BCD event counter.
//   MODE_*  : encodings of the 2-bit mode input
//   to_bcd  : elaboration-time conversion of an integer to packed BCD
package bcd_counter_pkg;

  localparam logic [1:0] MODE_UP       = 2'b00;
  localparam logic [1:0] MODE_DOWN     = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;
  localparam logic [1:0] MODE_MANUAL   = 2'b11;

  localparam int unsigned BCD_MAX_DIGITS = 16;

  // Packed BCD of value, ones digit in bits [3:0]; only used for constants.
  function automatic logic [4*BCD_MAX_DIGITS-1:0] to_bcd(input int unsigned value,
                                                         input int unsigned digits);
    logic [4*BCD_MAX_DIGITS-1:0] r;
    int unsigned v;
    r = '0;
    v = value;
    for (int unsigned i = 0; i < BCD_MAX_DIGITS; i++) begin
      if (i < digits) begin
        r[4*i +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_event_counter_digit.sv
// One decimal digit of an increment/decrement chain.
//   digit     : current BCD digit (0..9)
//   up        : 1 = increment, 0 = decrement
//   carry_in  : 1 = this digit must change (carry or borrow from below)
//   digit_next: resulting digit
//   carry_out : carry (up, 9->0) or borrow (down, 0->9) into the next digit
module bcd_digit_step (
  input  logic [3:0] digit,
  input  logic       up,
  input  logic       carry_in,
  output logic [3:0] digit_next,
  output logic       carry_out
);

  always_comb begin
    digit_next = digit;
    carry_out  = 1'b0;
    if (carry_in) begin
      if (up) begin
        if (digit >= 4'd9) begin
          digit_next = 4'd0;
          carry_out  = 1'b1;
        end else begin
          digit_next = digit + 4'd1;
        end
      end else begin
        if (digit == 4'd0) begin
          digit_next = 4'd9;
          carry_out  = 1'b1;
        end else begin
          digit_next = digit - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_event_counter.sv
// Prescaled up/down/ping-pong/manual event counter keeping a binary value
// and an N-digit packed BCD value in lockstep.
//   clk, reset : clock, synchronous active-high reset
//   btn        : single-cycle step pulse (manual mode only)
//   stop       : freezes prescaler and counting
//   speed      : 0 = DIV_SLOW, 1 = DIV_FAST clk cycles per step
//   mode       : 00 up, 01 down, 10 ping-pong, 11 manual
//   count_bcd  : packed BCD count, ones digit in [3:0]
//   count_bin  : binary count
//   led        : count_bin resized to LED_W
//   tick       : pulses for each applied step
//   wrap       : pulses on wrap or ping-pong direction reversal
module bcd_event_counter #(
  parameter int unsigned DIGITS    = 3,
  parameter int unsigned MAX_COUNT = 255,
  parameter int unsigned DIV_SLOW  = 50_000_000,
  parameter int unsigned DIV_FAST  = 5_000_000,
  parameter int unsigned LED_W     = 8
) (
  input  logic                                                    clk,
  input  logic                                                    reset,
  input  logic                                                    btn,
  input  logic                                                    stop,
  input  logic                                                    speed,
  input  logic [1:0]                                              mode,
  output logic [4*DIGITS-1:0]                                     count_bcd,
  output logic [((MAX_COUNT > 0) ? $clog2(MAX_COUNT + 1) : 1)-1:0] count_bin,
  output logic [LED_W-1:0]                                        led,
  output logic                                                    tick,
  output logic                                                    wrap
);
  import bcd_counter_pkg::*;

  localparam int unsigned CW      = (MAX_COUNT > 0) ? $clog2(MAX_COUNT + 1) : 1;
  localparam int unsigned BCD_W   = 4 * DIGITS;
  localparam int unsigned DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int unsigned PW      = $clog2(DIV_MAX);

  localparam logic [BCD_W-1:0] BCD_MAX = BCD_W'(to_bcd(MAX_COUNT, DIGITS));
  localparam logic [CW-1:0]    BIN_MAX = CW'(MAX_COUNT);

  logic [PW-1:0]    pre;
  logic [PW-1:0]    pre_next;
  logic [PW-1:0]    div_last;
  logic             speed_q;
  logic [1:0]       mode_q;
  logic             dir_up;
  logic             manual;
  logic             speed_chg;
  logic             step_en;
  logic             dir_eff;
  logic             at_max;
  logic             at_zero;
  logic             chain_up;
  logic             flip_dir;
  logic             wrap_c;
  logic [CW-1:0]    bin_next;
  logic [BCD_W-1:0] bcd_next;
  logic [BCD_W-1:0] bcd_stepped;
  logic [DIGITS:0]  carry;
  logic             unused_carry;

  // Prescaler and step enable generation.
  always_comb begin
    manual    = (mode == MODE_MANUAL);
    speed_chg = (speed != speed_q);
    div_last  = speed ? PW'(DIV_FAST - 1) : PW'(DIV_SLOW - 1);
    pre_next  = pre;
    step_en   = 1'b0;
    if (manual) begin
      pre_next = '0;
      step_en  = btn & ~stop;
    end else if (speed_chg) begin
      pre_next = '0;
    end else if (!stop) begin
      if (pre >= div_last) begin
        pre_next = '0;
        step_en  = 1'b1;
      end else begin
        pre_next = pre + PW'(1);
      end
    end
  end

  // Direction of the BCD chain; ping-pong turns reverse the nominal direction.
  always_comb begin
    dir_eff = (mode_q == MODE_PINGPONG) ? dir_up : 1'b1;
    at_max  = (count_bin == BIN_MAX);
    at_zero = (count_bin == '0);
    case (mode)
      MODE_DOWN:     chain_up = 1'b0;
      MODE_PINGPONG: chain_up = dir_eff ? ~at_max : at_zero;
      default:       chain_up = 1'b1;
    endcase
  end

  assign carry[0]     = 1'b1;
  assign unused_carry = carry[DIGITS];

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_step u_step (
      .digit      (count_bcd[4*i +: 4]),
      .up         (chain_up),
      .carry_in   (carry[i]),
      .digit_next (bcd_stepped[4*i +: 4]),
      .carry_out  (carry[i+1])
    );
  end

  // Next count for an applied step.
  always_comb begin
    bin_next = count_bin;
    bcd_next = count_bcd;
    wrap_c   = 1'b0;
    flip_dir = 1'b0;
    if (MAX_COUNT == 0) begin
      wrap_c = 1'b1;
    end else begin
      case (mode)
        MODE_DOWN: begin
          if (at_zero) begin
            bin_next = BIN_MAX;
            bcd_next = BCD_MAX;
            wrap_c   = 1'b1;
          end else begin
            bin_next = count_bin - CW'(1);
            bcd_next = bcd_stepped;
          end
        end
        MODE_PINGPONG: begin
          bcd_next = bcd_stepped;
          bin_next = chain_up ? count_bin + CW'(1) : count_bin - CW'(1);
          if (dir_eff ? at_max : at_zero) begin
            wrap_c   = 1'b1;
            flip_dir = 1'b1;
          end
        end
        default: begin
          if (at_max) begin
            bin_next = '0;
            bcd_next = '0;
            wrap_c   = 1'b1;
          end else begin
            bin_next = count_bin + CW'(1);
            bcd_next = bcd_stepped;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre       <= '0;
      speed_q   <= 1'b0;
      mode_q    <= MODE_UP;
      dir_up    <= 1'b1;
      count_bin <= '0;
      count_bcd <= '0;
      tick      <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      pre     <= pre_next;
      speed_q <= speed;
      mode_q  <= mode;
      tick    <= step_en;
      wrap    <= step_en & wrap_c;
      if (mode == MODE_PINGPONG) begin
        dir_up <= (step_en & flip_dir) ? ~dir_eff : dir_eff;
      end
      if (step_en) begin
        count_bin <= bin_next;
        count_bcd <= bcd_next;
      end
    end
  end

  assign led = LED_W'(count_bin);

endmodule

// File: tb/tb_bcd_event_counter.sv
// Self-checking bench: two counter instances compared every cycle against a
// behavioural model, plus directed literal checks of key scenarios.
module tb_bcd_event_counter;

  logic        clk;
  logic        reset1, btn1, stop1, speed1;
  logic [1:0]  mode1;
  logic [11:0] bcd1;
  logic [3:0]  bin1;
  logic [7:0]  led1;
  logic        tick1, wrap1;

  logic        reset2, btn2, stop2, speed2;
  logic [1:0]  mode2;
  logic [15:0] bcd2;
  logic [13:0] bin2;
  logic [3:0]  led2;
  logic        tick2, wrap2;

  int n_checks = 0;
  int n_errors = 0;

  bcd_event_counter #(.DIGITS(3), .MAX_COUNT(12), .DIV_SLOW(4), .DIV_FAST(2), .LED_W(8)) dut1 (
    .clk(clk), .reset(reset1), .btn(btn1), .stop(stop1), .speed(speed1), .mode(mode1),
    .count_bcd(bcd1), .count_bin(bin1), .led(led1), .tick(tick1), .wrap(wrap1)
  );

  bcd_event_counter #(.DIGITS(4), .MAX_COUNT(9999), .DIV_SLOW(3), .DIV_FAST(2), .LED_W(4)) dut2 (
    .clk(clk), .reset(reset2), .btn(btn2), .stop(stop2), .speed(speed2), .mode(mode2),
    .count_bcd(bcd2), .count_bin(bin2), .led(led2), .tick(tick2), .wrap(wrap2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int      pre;
    bit      dir_up;
    bit      speed_q;
    bit [1:0] mode_q;
    int      cnt;
    bit      tick;
    bit      wrap;
  } mstate_t;

  mstate_t m1, m2;
  bit started1 = 1'b0;
  bit started2 = 1'b0;

  function automatic mstate_t model_next(input mstate_t s, input bit rst, input bit btn,
                                         input bit stop, input bit speed, input bit [1:0] mode,
                                         input int maxc, input int dslow, input int dfast);
    mstate_t n;
    bit step;
    bit d;
    int div;
    n = s;
    if (rst) begin
      n.pre = 0; n.dir_up = 1'b1; n.speed_q = 1'b0; n.mode_q = 2'd0;
      n.cnt = 0; n.tick = 1'b0; n.wrap = 1'b0;
      return n;
    end
    div  = speed ? dfast : dslow;
    step = 1'b0;
    if (mode == 2'd3) begin
      step  = btn && !stop;
      n.pre = 0;
    end else if (speed != s.speed_q) begin
      n.pre = 0;
    end else if (!stop) begin
      if (s.pre == div - 1) begin
        step  = 1'b1;
        n.pre = 0;
      end else begin
        n.pre = s.pre + 1;
      end
    end
    d = (mode == 2'd2 && s.mode_q != 2'd2) ? 1'b1 : s.dir_up;
    n.tick = step;
    n.wrap = 1'b0;
    if (step) begin
      case (mode)
        2'd1: begin
          n.wrap = (s.cnt == 0);
          n.cnt  = (s.cnt + maxc) % (maxc + 1);
        end
        2'd2: begin
          if (maxc == 0) n.wrap = 1'b1;
          else if (d && s.cnt == maxc) begin d = 1'b0; n.cnt = maxc - 1; n.wrap = 1'b1; end
          else if (!d && s.cnt == 0) begin d = 1'b1; n.cnt = 1; n.wrap = 1'b1; end
          else n.cnt = d ? s.cnt + 1 : s.cnt - 1;
        end
        default: begin
          n.wrap = (s.cnt == maxc);
          n.cnt  = (s.cnt + 1) % (maxc + 1);
        end
      endcase
    end
    if (mode == 2'd2) n.dir_up = d;
    n.speed_q = speed;
    n.mode_q  = mode;
    return n;
  endfunction

  function automatic logic [63:0] dec_bcd(input int v);
    logic [63:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 16; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances on the same edge the DUTs sample their inputs.
  always @(posedge clk) begin
    m1 = model_next(m1, reset1, btn1, stop1, speed1, mode1, 12, 4, 2);
    m2 = model_next(m2, reset2, btn2, stop2, speed2, mode2, 9999, 3, 2);
    if (reset1) started1 = 1'b1;
    if (reset2) started2 = 1'b1;
  end

  always @(negedge clk) begin
    if (started1) begin
      check("d1_count_bin", 64'(bin1),  64'(m1.cnt));
      check("d1_count_bcd", 64'(bcd1),  dec_bcd(m1.cnt));
      check("d1_led",       64'(led1),  64'(m1.cnt % 256));
      check("d1_tick",      64'(tick1), 64'(m1.tick));
      check("d1_wrap",      64'(wrap1), 64'(m1.wrap));
    end
    if (started2) begin
      check("d2_count_bin", 64'(bin2),  64'(m2.cnt));
      check("d2_count_bcd", 64'(bcd2),  dec_bcd(m2.cnt));
      check("d2_led",       64'(led2),  64'(m2.cnt % 16));
      check("d2_tick",      64'(tick2), 64'(m2.tick));
      check("d2_wrap",      64'(wrap2), 64'(m2.wrap));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  int wraps;
  int ticks;
  int expv;

  initial begin
    m1 = '{pre: 0, dir_up: 1'b1, speed_q: 1'b0, mode_q: 2'd0, cnt: 0, tick: 1'b0, wrap: 1'b0};
    m2 = m1;
    reset1 = 1'b1; btn1 = 1'b0; stop1 = 1'b0; speed1 = 1'b0; mode1 = 2'd0;
    reset2 = 1'b1; btn2 = 1'b0; stop2 = 1'b0; speed2 = 1'b1; mode2 = 2'd0;

    // Up count with wrap at 12.
    cyc();
    reset1 = 1'b0;
    check("reset_bin", 64'(bin1), 64'd0);
    check("reset_bcd", 64'(bcd1), 64'd0);
    wraps = 0; ticks = 0;
    for (int i = 1; i <= 56; i++) begin
      cyc();
      wraps += int'(wrap1);
      ticks += int'(tick1);
      if (i == 48) begin
        check("up_at_max_bin", 64'(bin1), 64'd12);
        check("up_at_max_bcd", 64'(bcd1), 64'h012);
        check("up_at_max_led", 64'(led1), 64'd12);
      end
      if (i == 52) begin
        check("up_wrap_bin",  64'(bin1),  64'd0);
        check("up_wrap_bcd",  64'(bcd1),  64'h000);
        check("up_wrap_flag", 64'(wrap1), 64'd1);
      end
    end
    check("up_wrap_pulses", 64'(wraps), 64'd1);
    check("up_tick_count",  64'(ticks), 64'd14);

    // Down count: first step wraps to MAX, later BCD borrow 10 -> 9.
    reset1 = 1'b1; mode1 = 2'd1;
    cyc();
    reset1 = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      if (i == 4) begin
        check("down_first_bin",  64'(bin1),  64'd12);
        check("down_first_bcd",  64'(bcd1),  64'h012);
        check("down_first_wrap", 64'(wrap1), 64'd1);
      end
      if (i == 12) check("down_ten_bcd", 64'(bcd1), 64'h010);
      if (i == 16) begin
        check("down_nine_bcd", 64'(bcd1), 64'h009);
        check("down_nine_bin", 64'(bin1), 64'd9);
      end
    end

    // Ping-pong at the fast rate: 0..12..0,1 with wrap only at the turns.
    reset1 = 1'b1; mode1 = 2'd2; speed1 = 1'b1;
    cyc();
    reset1 = 1'b0;
    cyc();
    for (int i = 1; i <= 25; i++) begin
      cyc();
      cyc();
      expv = (i <= 12) ? i : ((i <= 24) ? 24 - i : i - 24);
      check("pp_bin",  64'(bin1),  64'(expv));
      check("pp_wrap", 64'(wrap1), 64'((i == 13) || (i == 25)));
    end

    // Stop mid-prescale, then a speed change restarting the prescaler.
    reset1 = 1'b1; mode1 = 2'd0; speed1 = 1'b0;
    cyc();
    reset1 = 1'b0;
    cyc(); cyc();
    stop1 = 1'b1;
    repeat (10) cyc();
    check("stop_frozen", 64'(bin1), 64'd0);
    stop1 = 1'b0;
    cyc();
    check("resume_no_tick", 64'(tick1), 64'd0);
    cyc();
    check("resume_tick", 64'(tick1), 64'd1);
    check("resume_bin",  64'(bin1),  64'd1);
    cyc();
    speed1 = 1'b1;
    cyc();
    check("speed_chg_suppress", 64'(tick1), 64'd0);
    cyc();
    check("speed_restart_bin", 64'(bin1), 64'd1);
    cyc();
    check("speed_tick", 64'(tick1), 64'd1);
    check("speed_bin",  64'(bin1),  64'd2);

    // Manual: three steps, a fourth button press lost while stopped.
    reset1 = 1'b1; mode1 = 2'd3; speed1 = 1'b0;
    cyc();
    reset1 = 1'b0;
    ticks = 0;
    for (int p = 0; p < 4; p++) begin
      btn1 = 1'b1; stop1 = (p == 3);
      cyc();
      btn1 = 1'b0; stop1 = 1'b0;
      check("man_tick_after_btn", 64'(tick1), 64'(p < 3));
      ticks += int'(tick1);
      repeat (2) begin
        cyc();
        ticks += int'(tick1);
      end
    end
    check("man_bin",   64'(bin1),  64'd3);
    check("man_bcd",   64'(bcd1),  64'h003);
    check("man_ticks", 64'(ticks), 64'd3);

    // Reset colliding with a step at count 7.
    for (int p = 0; p < 4; p++) begin
      btn1 = 1'b1; cyc(); btn1 = 1'b0; cyc();
    end
    check("pre_reset_bin", 64'(bin1), 64'd7);
    reset1 = 1'b1; btn1 = 1'b1;
    cyc();
    reset1 = 1'b0; btn1 = 1'b0;
    check("rst_bin",  64'(bin1),  64'd0);
    check("rst_bcd",  64'(bcd1),  64'd0);
    check("rst_led",  64'(led1),  64'd0);
    check("rst_tick", 64'(tick1), 64'd0);
    check("rst_wrap", 64'(wrap1), 64'd0);
    mode1 = 2'd2;
    repeat (4) cyc();
    check("rst_dir_up", 64'(bin1), 64'd1);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset1 = ($urandom_range(0, 299) == 0);
      btn1   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) stop1 = ~stop1;
      if ($urandom_range(0, 99) == 0) mode1 = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0) speed1 = ~speed1;
      cyc();
    end
    reset1 = 1'b0; stop1 = 1'b0;

    // Four-digit instance runs to 9999 and wraps.
    cyc();
    reset2 = 1'b0;
    repeat (19999) cyc();
    check("big_max_bin", 64'(bin2), 64'd9999);
    check("big_max_bcd", 64'(bcd2), 64'h9999);
    check("big_max_led", 64'(led2), 64'd15);
    cyc(); cyc();
    check("big_wrap_bcd",  64'(bcd2),  64'h0000);
    check("big_wrap_flag", 64'(wrap2), 64'd1);

    cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
